// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline stage register, LANES words of W bits per entry.
// Two-entry skid buffer (main + skid) keeps full throughput under back-pressure
// while in_ready is decoded from registered state only. Flush and reset empty
// the stage and zero the datapath, so a bubble shows as NOP / PC 0.
// Optional feature macro: PIPE_STAT_EN adds stall_cnt / bubble_cnt counters.
module pipe_skid_stage #(
  parameter int W     = 32,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data
`ifdef PIPE_STAT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [LANES*W-1:0] main_q, main_d;
  logic [LANES*W-1:0] skid_q, skid_d;
  logic               push, pop;

  // Handshake decoded purely from registered state: no in_* -> out_* path.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state and datapath selection; main is zeroed whenever the stage empties.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (pop) begin
          main_d  = '0;
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can move the stage.
        if (pop) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        main_d  = '0;
        skid_d  = '0;
        state_d = EMPTY;
      end
    endcase
    // Flush overrides the handshake: a concurrent push is dropped, a concurrent
    // pop still sees the current out_data.
    if (flush) begin
      main_d  = '0;
      skid_d  = '0;
      state_d = EMPTY;
    end
  end

  // State and payload registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] bubble_q, bubble_d;

  // Stall: upstream offers but we refuse. Bubble: downstream ready, nothing to give.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (in_valid && !in_ready)   stall_d  = stall_q + 32'd1;
    if (out_ready && !out_valid) bubble_d = bubble_q + 32'd1;
  end

  // Counters clear on reset only; flush leaves them running.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage (W=32, LANES=4); counter checks only when
// PIPE_STAT_EN is defined.
module tb_pipe_skid_stage;
  localparam int W     = 32;
  localparam int LANES = 4;
  localparam int PW    = W * LANES;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [PW-1:0] in_data, out_data;
`ifdef PIPE_STAT_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  pipe_skid_stage #(.W(W), .LANES(LANES)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Payload: lane 0 carries v, lane i>0 carries i.
  function automatic logic [PW-1:0] pay(input logic [W-1:0] v);
    logic [PW-1:0] p;
    p = '0;
    p[0 +: W] = v;
    for (int i = 1; i < LANES; i++) p[i*W +: W] = W'(i);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream rule: while an offer is pending, in_data must not change.
  logic          pend = 1'b0;
  logic [PW-1:0] pend_data = '0;
  always @(posedge clk) begin
    if (pend && in_valid && !reset && !flush && in_data !== pend_data) begin
      fails++;
      $error("FAIL upstream_stable: observed %0h expected %0h", in_data, pend_data);
    end
    pend      = in_valid & ~in_ready & ~reset & ~flush;
    pend_data = in_data;
  end

  initial begin
    // Reset held 2 cycles with a live-looking input.
    reset = 1; flush = 0; out_ready = 0; in_valid = 1;
    in_data = {(PW/8){8'hA5}};
    step(); step();
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_out_data",  out_data,       '0);
    chk("rst_in_ready",  PW'(in_ready),  PW'(1));
    reset = 0; in_valid = 0;
    step();
    chk("rst_no_capture", PW'(out_valid), PW'(0));

    // Streaming at full rate.
    out_ready = 1; in_valid = 1; in_data = pay(1);
    step();
    chk("str_v1",  PW'(out_valid), PW'(1));
    chk("str_d1",  out_data, pay(1));
    chk("str_rdy1", PW'(in_ready), PW'(1));
    in_data = pay(2);
    step();
    chk("str_d2",  out_data, pay(2));
    chk("str_rdy2", PW'(in_ready), PW'(1));
    in_data = pay(3);
    step();
    chk("str_d3",  out_data, pay(3));
    in_valid = 0;
    step();
    chk("str_empty_v", PW'(out_valid), PW'(0));
    chk("str_empty_d", out_data, '0);

    // Back-pressure: 0x10 held, 0x11 skidded, 0x12 waits.
    out_ready = 0; in_valid = 1; in_data = pay(32'h10);
    step();
    chk("bp_d10a", out_data, pay(32'h10));
    chk("bp_rdy_one", PW'(in_ready), PW'(1));
    in_data = pay(32'h11);
    step();
    chk("bp_d10b", out_data, pay(32'h10));
    chk("bp_rdy_two", PW'(in_ready), PW'(0));
    in_data = pay(32'h12);
    step();
    chk("bp_d10c", out_data, pay(32'h10));
    chk("bp_rdy_hold", PW'(in_ready), PW'(0));
    out_ready = 1;
    step();
    chk("bp_d11", out_data, pay(32'h11));
    chk("bp_rdy_back", PW'(in_ready), PW'(1));
    step();
    chk("bp_d12", out_data, pay(32'h12));
    chk("bp_v12", PW'(out_valid), PW'(1));
    in_valid = 0;
    step();
    chk("bp_drained", PW'(out_valid), PW'(0));

    // Flush in TWO with a concurrent offer of 0x20.
    out_ready = 0; in_valid = 1; in_data = pay(32'h40);
    step();
    in_data = pay(32'h41);
    step();
    chk("fl_two", PW'(in_ready), PW'(0));
    flush = 1; in_data = pay(32'h20);
    step();
    chk("fl_v",   PW'(out_valid), PW'(0));
    chk("fl_d",   out_data, '0);
    chk("fl_rdy", PW'(in_ready), PW'(1));
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    chk("fl_no20", PW'(out_valid), PW'(0));

    // Flush together with a pop from ONE: stage still empties.
    out_ready = 0; in_valid = 1; in_data = pay(32'h50);
    step();
    in_valid = 0; out_ready = 1; flush = 1;
    step();
    flush = 0;
    chk("flpop_v", PW'(out_valid), PW'(0));
    chk("flpop_d", out_data, '0);

    // Drain: push 0x30, then pop with no new push.
    out_ready = 0; in_valid = 1; in_data = pay(32'h30);
    step();
    chk("dr_d30", out_data, pay(32'h30));
    in_valid = 0; out_ready = 1;
    step();
    chk("dr_v",   PW'(out_valid), PW'(0));
    chk("dr_d",   out_data, '0);
    chk("dr_rdy", PW'(in_ready), PW'(1));

    // Reset while in TWO loses both entries.
    out_ready = 0; in_valid = 1; in_data = pay(32'h60);
    step();
    in_data = pay(32'h61);
    step();
    chk("rt_two", PW'(in_ready), PW'(0));
    in_valid = 0; reset = 1;
    step();
    reset = 0;
    chk("rt_rdy", PW'(in_ready), PW'(1));
    chk("rt_v",   PW'(out_valid), PW'(0));
    chk("rt_d",   out_data, '0);

`ifdef PIPE_STAT_EN
    // 10 cycles of offer with no drain: 2 accepted, 8 stalled.
    in_valid = 1; out_ready = 0; in_data = pay(32'h70);
    for (int c = 0; c < 10; c++) step();
    chk("cnt_stall8",  PW'(stall_cnt),  PW'(8));
    chk("cnt_bubble0", PW'(bubble_cnt), PW'(0));
    // Flush does not clear the counters.
    in_valid = 0; flush = 1;
    step();
    flush = 0;
    chk("cnt_flush_keep", PW'(stall_cnt), PW'(8));
    reset = 1;
    step();
    reset = 0; out_ready = 1; in_valid = 0;
    for (int c = 0; c < 5; c++) step();
    chk("cnt_bubble5", PW'(bubble_cnt), PW'(5));
    chk("cnt_stall0",  PW'(stall_cnt),  PW'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
